vending_machine: RTL and testbench

// - Ticket vending controller for a 5-station line (S1..S5), 1..5 tickets per sale.
// - Sequence: latch origin/destination -> latch ticket count -> accumulate coins -> dispense/change.
// - Reports per-ticket fare, amount still owed and money inserted; standalone top-level block.

---
 rtl/vm_pkg.sv | 29 ++
 rtl/vm_fare_calc.sv | 22 ++
 rtl/vending_machine.sv | 118 +++++++++++
 tb/tb_vending_machine.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared types and constants for the ticket vending controller.
package vm_pkg;

  localparam int unsigned NUM_STATIONS = 5;
  localparam int unsigned MAX_TICKETS  = 5;
  localparam int unsigned FARE_BASE    = 5;
  localparam int unsigned FARE_STEP    = 5;

  localparam logic [5:0] COIN_1  = 6'd1;
  localparam logic [5:0] COIN_5  = 6'd5;
  localparam logic [5:0] COIN_10 = 6'd10;
  localparam logic [5:0] COIN_50 = 6'd50;

  typedef enum logic [1:0] {
    ST_STATION,
    ST_TICKET,
    ST_PAY,
    ST_DONE
  } vm_state_e;

  function automatic logic is_coin(input logic [5:0] v);
    return (v == COIN_1) || (v == COIN_5) || (v == COIN_10) || (v == COIN_50);
  endfunction

  function automatic logic in_range(input logic [2:0] v, input int unsigned hi);
    return (v != 3'd0) && ({29'd0, v} <= hi);
  endfunction

endpackage

// File: rtl/vm_fare_calc.sv
// Combinational per-ticket fare: base plus a fixed step per station hop.
module vm_fare_calc
  import vm_pkg::*;
(
  input  logic [2:0] i_origin,
  input  logic [2:0] i_destination,
  output logic       o_valid,
  output logic [6:0] o_fare
);

  logic [2:0] w_hops;

  always_comb begin
    w_hops  = (i_destination > i_origin) ? (i_destination - i_origin)
                                         : (i_origin - i_destination);
    o_valid = in_range(i_origin, NUM_STATIONS) &&
              in_range(i_destination, NUM_STATIONS) &&
              (i_origin != i_destination);
    o_fare  = 7'(FARE_BASE) + 7'(FARE_STEP) * {4'd0, w_hops};
  end

endmodule

// File: rtl/vending_machine.sv
// Ticket vending controller: stations -> ticket count -> coin accumulation -> done.
module vending_machine
  import vm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] origin,
  input  logic [2:0] destination,
  input  logic [2:0] howManyTicket,
  input  logic [5:0] money,
  output logic [6:0] costOfTicket,
  output logic [6:0] moneyToPay,
  output logic [6:0] totalMoney
);

  vm_state_e  r_state, w_state_nxt;
  logic [2:0] r_orig, r_dest, r_count;
  logic [6:0] r_cost, r_topay, r_total;

  logic [2:0] w_orig_nxt, w_dest_nxt, w_count_nxt;
  logic [6:0] w_cost_nxt, w_topay_nxt, w_total_nxt;

  logic [2:0] w_fc_orig, w_fc_dest;
  logic       w_fare_valid;
  logic [6:0] w_fare;
  logic [6:0] w_due;
  logic [7:0] w_sum;
  logic       w_count_ok;
  logic       w_coin_ok;
  logic       w_paid;

  // The fare block sees the live inputs while choosing a trip, the latched trip afterwards.
  assign w_fc_orig = (r_state == ST_STATION) ? origin      : r_orig;
  assign w_fc_dest = (r_state == ST_STATION) ? destination : r_dest;

  vm_fare_calc u_fare (
    .i_origin      (w_fc_orig),
    .i_destination (w_fc_dest),
    .o_valid       (w_fare_valid),
    .o_fare        (w_fare)
  );

  assign w_due      = w_fare * 7'(r_count);
  assign w_sum      = {1'b0, r_total} + {2'd0, money};
  assign w_count_ok = in_range(howManyTicket, MAX_TICKETS);
  assign w_coin_ok  = is_coin(money) && (w_sum <= 8'd127);
  assign w_paid     = w_sum >= {1'b0, w_due};

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_STATION;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_STATION: if (w_fare_valid)          w_state_nxt = ST_TICKET;
      ST_TICKET:  if (w_count_ok)            w_state_nxt = ST_PAY;
      ST_PAY:     if (w_coin_ok && w_paid)   w_state_nxt = ST_DONE;
      ST_DONE:                               w_state_nxt = ST_DONE;
      default:                               w_state_nxt = ST_STATION;
    endcase
  end

  always_comb begin
    w_orig_nxt  = r_orig;
    w_dest_nxt  = r_dest;
    w_count_nxt = r_count;
    w_cost_nxt  = r_cost;
    w_topay_nxt = r_topay;
    w_total_nxt = r_total;
    unique case (r_state)
      ST_STATION: begin
        if (w_fare_valid) begin
          w_orig_nxt = origin;
          w_dest_nxt = destination;
          w_cost_nxt = w_fare;
        end
      end
      ST_TICKET: begin
        if (w_count_ok) begin
          w_count_nxt = howManyTicket;
          w_topay_nxt = w_fare * 7'(howManyTicket);
        end
      end
      ST_PAY: begin
        if (w_coin_ok) begin
          w_total_nxt = w_sum[6:0];
          w_topay_nxt = w_paid ? '0 : (w_due - w_sum[6:0]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_orig  <= '0;
      r_dest  <= '0;
      r_count <= '0;
      r_cost  <= '0;
      r_topay <= '0;
      r_total <= '0;
    end else begin
      r_orig  <= w_orig_nxt;
      r_dest  <= w_dest_nxt;
      r_count <= w_count_nxt;
      r_cost  <= w_cost_nxt;
      r_topay <= w_topay_nxt;
      r_total <= w_total_nxt;
    end
  end

  assign costOfTicket = r_cost;
  assign moneyToPay   = r_topay;
  assign totalMoney   = r_total;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine with hand-computed expected values.
module tb_vending_machine;
  import vm_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] origin, destination, howManyTicket;
  logic [5:0] money;
  logic [6:0] costOfTicket, moneyToPay, totalMoney;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  vending_machine dut (
    .clk           (clk),
    .reset         (reset),
    .origin        (origin),
    .destination   (destination),
    .howManyTicket (howManyTicket),
    .money         (money),
    .costOfTicket  (costOfTicket),
    .moneyToPay    (moneyToPay),
    .totalMoney    (totalMoney)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input int cost, input int topay, input int total);
    check({tag, ".cost"},  int'(costOfTicket), cost);
    check({tag, ".topay"}, int'(moneyToPay),   topay);
    check({tag, ".total"}, int'(totalMoney),   total);
  endtask

  task automatic st(input string tag, input vm_state_e exp);
    check({tag, ".state"}, int'(dut.r_state), int'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [2:0] bad_o [4] = '{3'd3, 3'd0, 3'd6, 3'd2};
  logic [2:0] bad_d [4] = '{3'd3, 3'd2, 3'd1, 3'd7};
  logic [5:0] coins [5] = '{6'd50, 6'd10, 6'd5, 6'd5, 6'd10};
  int         tot_e [5] = '{50, 60, 65, 70, 80};
  int         pay_e [5] = '{25, 15, 10, 5, 0};

  initial begin
    reset = 1'b1; origin = '0; destination = '0; howManyTicket = '0; money = '0;
    step();
    outs("rst0", 0, 0, 0);
    st("rst0", ST_STATION);
    reset = 1'b0;

    // Sale 1: 2->5, two tickets, partial payment then reset.
    origin = 3'd2; destination = 3'd5; step();
    outs("s1.trip", 20, 0, 0);
    howManyTicket = 3'd2; step();
    outs("s1.count", 20, 40, 0);
    money = 6'd10; step();
    outs("s1.coin1", 20, 30, 10);
    step();
    outs("s1.coin2", 20, 20, 20);
    check("s1.refund", int'(totalMoney), 20);
    money = '0;
    do_reset();
    outs("s1.rst", 0, 0, 0);
    st("s1.rst", ST_STATION);

    // Reset right after the trip is latched.
    origin = 3'd1; destination = 3'd3; step();
    outs("s2.trip", 15, 0, 0);
    do_reset();
    outs("s2.rst", 0, 0, 0);
    st("s2.rst", ST_STATION);

    // Invalid stations hold; money is ignored before ST_PAY.
    money = 6'd10;
    for (int i = 0; i < 4; i++) begin
      origin = bad_o[i]; destination = bad_d[i]; step();
      outs($sformatf("badst%0d", i), 0, 0, 0);
      st($sformatf("badst%0d", i), ST_STATION);
    end
    origin = 3'd3; destination = 3'd5; step();
    outs("s3.trip", 15, 0, 0);
    howManyTicket = 3'd0; step();
    outs("badcnt0", 15, 0, 0);
    st("badcnt0", ST_TICKET);
    howManyTicket = 3'd6; money = 6'd50; step();
    outs("badcnt6", 15, 0, 0);
    st("badcnt6", ST_TICKET);
    howManyTicket = 3'd5; money = '0; step();
    outs("s3.count", 15, 75, 0);
    st("s3.count", ST_PAY);
    money = 6'd3; step();
    outs("coin3", 15, 75, 0);
    money = 6'd0; step();
    outs("coin0", 15, 75, 0);
    for (int i = 0; i < 5; i++) begin
      money = coins[i]; step();
      outs($sformatf("s3.pay%0d", i), 15, pay_e[i], tot_e[i]);
    end
    st("s3.done", ST_DONE);
    check("s3.change", int'(totalMoney) - 75, 5);
    check("s3.tickets", int'(dut.r_count), 5);
    money = 6'd50; origin = 3'd1; destination = 3'd2; howManyTicket = 3'd1; step();
    outs("s3.hold", 15, 0, 80);
    st("s3.hold", ST_DONE);
    money = '0;

    // Overflow rejection: 1->5 x5 = 125.
    do_reset();
    outs("s4.rst", 0, 0, 0);
    origin = 3'd1; destination = 3'd5; step();
    howManyTicket = 3'd5; step();
    outs("s4.count", 25, 125, 0);
    money = 6'd50; step(); step();
    outs("s4.p100", 25, 25, 100);
    money = 6'd10; step(); step();
    outs("s4.p120", 25, 5, 120);
    money = 6'd50; step();
    outs("s4.ovf50", 25, 5, 120);
    money = 6'd10; step();
    outs("s4.ovf10", 25, 5, 120);
    st("s4.ovf", ST_PAY);
    money = 6'd5; step();
    outs("s4.exact", 25, 0, 125);
    st("s4.exact", ST_DONE);
    money = '0;

    // Reset in ST_DONE, then a fresh sale 4->2 x1.
    do_reset();
    outs("s5.rst", 0, 0, 0);
    st("s5.rst", ST_STATION);
    origin = 3'd4; destination = 3'd2; step();
    howManyTicket = 3'd1; step();
    outs("s5.count", 15, 15, 0);
    money = 6'd10; step();
    outs("s5.p10", 15, 5, 10);
    money = 6'd5; step();
    outs("s5.p15", 15, 0, 15);
    st("s5.done", ST_DONE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
